// File: rtl/regfile_wb_arbiter_if.sv
// Issue, writeback-source and register-file write signals of the writeback arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    localparam int unsigned CW = 6;

    // Issue stage
    logic            Issue_Valid;
    logic [AW-1:0]   Issue_SR1;
    logic [AW-1:0]   Issue_SR2;
    logic [AW-1:0]   Issue_DR;
    logic            Issue_WB;
    logic            Issue_Stall;

    // Writeback source A (ALU)
    logic            A_Valid;
    logic [AW-1:0]   A_DR;
    logic [XLEN-1:0] A_Data;
    logic            A_Ready;

    // Writeback source B (LSU)
    logic            B_Valid;
    logic [AW-1:0]   B_DR;
    logic [XLEN-1:0] B_Data;
    logic            B_Ready;

    // Register file write port and status
    logic            RegW;
    logic [AW-1:0]   DR;
    logic [XLEN-1:0] Reg_In;
    logic [CW-1:0]   Busy_Count;
    logic            Err_Unexp;

    modport master (
        output Issue_Valid, Issue_SR1, Issue_SR2, Issue_DR, Issue_WB,
        output A_Valid, A_DR, A_Data,
        output B_Valid, B_DR, B_Data,
        input  Issue_Stall, A_Ready, B_Ready,
        input  RegW, DR, Reg_In, Busy_Count, Err_Unexp
    );

    modport slave (
        input  Issue_Valid, Issue_SR1, Issue_SR2, Issue_DR, Issue_WB,
        input  A_Valid, A_DR, A_Data,
        input  B_Valid, B_DR, B_Data,
        output Issue_Stall, A_Ready, B_Ready,
        output RegW, DR, Reg_In, Busy_Count, Err_Unexp
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port scheduler: round-robin on contention between ALU and LSU
// writebacks, plus a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input logic                 CLK,
    input logic                 RST,
    regfile_wb_arbiter_if.slave bus
);
    localparam int unsigned CW = 6;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    prio_e           prio_q, prio_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q;
    logic            regw_q;
    logic [AW-1:0]   dr_q;
    logic [XLEN-1:0] reg_in_q;

    logic            a_gnt_c, b_gnt_c, xfer_c;
    logic [AW-1:0]   gnt_dr_c;
    logic [XLEN-1:0] gnt_data_c;
    logic            stall_c, set_c, clr_c;

    // Priority register: names the source that wins the next contention cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) prio_q <= PRIO_A;
        else     prio_q <= prio_d;
    end

    // Grant selection; priority flips only when both sources request
    always_comb begin
        prio_d     = prio_q;
        a_gnt_c    = 1'b0;
        b_gnt_c    = 1'b0;
        gnt_dr_c   = bus.A_DR;
        gnt_data_c = bus.A_Data;
        if (bus.A_Valid && bus.B_Valid) begin
            if (prio_q == PRIO_A) begin
                a_gnt_c = 1'b1;
                prio_d  = PRIO_B;
            end else begin
                b_gnt_c = 1'b1;
                prio_d  = PRIO_A;
            end
        end else begin
            a_gnt_c = bus.A_Valid;
            b_gnt_c = bus.B_Valid;
        end
        if (b_gnt_c) begin
            gnt_dr_c   = bus.B_DR;
            gnt_data_c = bus.B_Data;
        end
    end

    assign xfer_c = a_gnt_c | b_gnt_c;

    // Hazard detection and next scoreboard contents; x0 is never marked busy
    always_comb begin
        stall_c = bus.Issue_Valid &&
                  (busy_q[bus.Issue_SR1] || busy_q[bus.Issue_SR2] ||
                   (bus.Issue_WB && busy_q[bus.Issue_DR]));
        set_c   = bus.Issue_Valid && !stall_c && bus.Issue_WB && (bus.Issue_DR != '0);
        clr_c   = regw_q && busy_q[dr_q];
        busy_d  = busy_q;
        if (clr_c) busy_d[dr_q] = 1'b0;
        if (set_c) busy_d[bus.Issue_DR] = 1'b1;
        busy_d[0] = 1'b0;
        cnt_d   = cnt_q + CW'(set_c) - CW'(clr_c);
    end

    // Scoreboard, pending-write count and sticky unexpected-write flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            if (regw_q && !busy_q[dr_q]) err_q <= 1'b1;
        end
    end

    // Register-file write stage; a write to x0 is transferred but not enabled
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            regw_q   <= 1'b0;
            dr_q     <= '0;
            reg_in_q <= '0;
        end else if (xfer_c) begin
            regw_q   <= (gnt_dr_c != '0);
            dr_q     <= gnt_dr_c;
            reg_in_q <= gnt_data_c;
        end else begin
            regw_q   <= 1'b0;
        end
    end

    assign bus.Issue_Stall = stall_c;
    assign bus.A_Ready     = a_gnt_c;
    assign bus.B_Ready     = b_gnt_c;
    assign bus.RegW        = regw_q;
    assign bus.DR          = dr_q;
    assign bus.Reg_In      = reg_in_q;
    assign bus.Busy_Count  = cnt_q;
    assign bus.Err_Unexp   = err_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized checks of the writeback arbiter against a behavioural model.
module tb_regfile_wb_arbiter;
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic CLK;
    logic RST;

    regfile_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus();

    regfile_wb_arbiter #(.XLEN(XLEN), .NREG(32), .AW(AW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    bit          m_busy [32];
    bit          m_prio_b;
    bit          m_regw;
    logic [4:0]  m_dr;
    logic [31:0] m_data;
    bit          m_err;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_prio_b = 1'b0;
        m_regw   = 1'b0;
        m_dr     = '0;
        m_data   = '0;
        m_err    = 1'b0;
    endfunction

    function automatic bit m_stall();
        return bus.Issue_Valid && (m_busy[bus.Issue_SR1] || m_busy[bus.Issue_SR2] ||
                                   (bus.Issue_WB && m_busy[bus.Issue_DR]));
    endfunction

    function automatic bit m_agnt();
        return bus.A_Valid && (!bus.B_Valid || !m_prio_b);
    endfunction

    function automatic bit m_bgnt();
        return bus.B_Valid && (!bus.A_Valid || m_prio_b);
    endfunction

    function automatic int m_count();
        int s = 0;
        foreach (m_busy[i]) s += int'(m_busy[i]);
        return s;
    endfunction

    // One clock edge of the model, evaluated from the inputs held across the edge
    function automatic void model_edge();
        bit ag = m_agnt();
        bit bg = m_bgnt();
        bit st = m_stall();
        if (m_regw) begin
            if (!m_busy[m_dr]) m_err = 1'b1;
            else               m_busy[m_dr] = 1'b0;
        end
        if (bus.Issue_Valid && !st && bus.Issue_WB && bus.Issue_DR != 5'd0)
            m_busy[bus.Issue_DR] = 1'b1;
        if (ag) begin
            m_regw = (bus.A_DR != 5'd0); m_dr = bus.A_DR; m_data = bus.A_Data;
        end else if (bg) begin
            m_regw = (bus.B_DR != 5'd0); m_dr = bus.B_DR; m_data = bus.B_Data;
        end else begin
            m_regw = 1'b0;
        end
        if (bus.A_Valid && bus.B_Valid) m_prio_b = !m_prio_b;
    endfunction

    function automatic logic [4:0] pick_dr();
        int q[$];
        for (int i = 1; i < 32; i++) if (m_busy[i]) q.push_back(i);
        if (q.size() == 0 || $urandom_range(0, 19) == 0) return 5'($urandom_range(0, 31));
        return 5'(q[$urandom_range(0, q.size() - 1)]);
    endfunction

    task automatic tick();
        @(posedge CLK);
        if (!RST) model_edge();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        bus.Issue_Valid = 1'b0; bus.Issue_SR1 = '0; bus.Issue_SR2 = '0;
        bus.Issue_DR = '0; bus.Issue_WB = 1'b0;
        bus.A_Valid = 1'b0; bus.A_DR = '0; bus.A_Data = '0;
        bus.B_Valid = 1'b0; bus.B_DR = '0; bus.B_Data = '0;
    endtask

    task automatic set_issue(input bit v, input int s1, input int s2, input int d, input bit wb);
        bus.Issue_Valid = v;
        bus.Issue_SR1   = AW'(s1);
        bus.Issue_SR2   = AW'(s2);
        bus.Issue_DR    = AW'(d);
        bus.Issue_WB    = wb;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b1;
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        model_reset();
        #2;
        set_issue(1, 5, 9, 12, 1);
        #1;
        n_vec++; if (bus.RegW !== 1'b0) begin n_err++; $display("FAIL reset_regw: got %0b want 0", bus.RegW); end
        n_vec++; if (bus.DR !== 5'd0) begin n_err++; $display("FAIL reset_dr: got %0d want 0", bus.DR); end
        n_vec++; if (bus.Reg_In !== 32'd0) begin n_err++; $display("FAIL reset_reg_in: got %h want 0", bus.Reg_In); end
        n_vec++; if (bus.Busy_Count !== 6'd0) begin n_err++; $display("FAIL reset_busy_count: got %0d want 0", bus.Busy_Count); end
        n_vec++; if (bus.Err_Unexp !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0b want 0", bus.Err_Unexp); end
        n_vec++; if (bus.Issue_Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0b want 0", bus.Issue_Stall); end
        @(negedge CLK);
        idle_inputs();
        RST = 1'b0;
    endtask

    task automatic test_raw_stall();
        do_reset();
        set_issue(1, 0, 0, 3, 1);
        #1;
        n_vec++; if (bus.Issue_Stall !== 1'b0) begin n_err++; $display("FAIL raw_first_issue: stall=%0b want 0", bus.Issue_Stall); end
        tick();
        set_issue(1, 3, 0, 0, 0);
        #1;
        n_vec++; if (bus.Issue_Stall !== 1'b1) begin n_err++; $display("FAIL raw_dep_stall: stall=%0b want 1", bus.Issue_Stall); end
        n_vec++; if (bus.Busy_Count !== 6'd1) begin n_err++; $display("FAIL raw_count_one: got %0d want 1", bus.Busy_Count); end
        tick();
        bus.A_Valid = 1'b1; bus.A_DR = 5'd3; bus.A_Data = 32'h1234_5678;
        #1;
        n_vec++; if (bus.A_Ready !== 1'b1) begin n_err++; $display("FAIL raw_a_grant: A_Ready=%0b want 1", bus.A_Ready); end
        n_vec++; if (bus.Issue_Stall !== 1'b1) begin n_err++; $display("FAIL raw_stall_grant: stall=%0b want 1", bus.Issue_Stall); end
        tick();
        bus.A_Valid = 1'b0;
        #1;
        n_vec++; if (bus.RegW !== 1'b1 || bus.DR !== 5'd3) begin n_err++; $display("FAIL raw_write: RegW=%0b DR=%0d want 1/3", bus.RegW, bus.DR); end
        n_vec++; if (bus.Reg_In !== 32'h1234_5678) begin n_err++; $display("FAIL raw_data: got %h want 12345678", bus.Reg_In); end
        n_vec++; if (bus.Issue_Stall !== 1'b1) begin n_err++; $display("FAIL raw_stall_writecycle: stall=%0b want 1", bus.Issue_Stall); end
        tick();
        #1;
        n_vec++; if (bus.Issue_Stall !== 1'b0) begin n_err++; $display("FAIL raw_release: stall=%0b want 0", bus.Issue_Stall); end
        n_vec++; if (bus.Busy_Count !== 6'd0) begin n_err++; $display("FAIL raw_count_zero: got %0d want 0", bus.Busy_Count); end
        idle_inputs();
    endtask

    task automatic test_contention();
        logic [4:0]  a_dr, b_dr, prev_dr;
        logic [31:0] prev_data;
        bit          exp_a;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            set_issue(1, 0, 0, i, 1);
            tick();
        end
        idle_inputs();
        a_dr = 5'd1; b_dr = 5'd5; prev_dr = '0; prev_data = '0;
        bus.A_Valid = 1'b1; bus.B_Valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.A_DR = a_dr; bus.A_Data = $urandom;
            bus.B_DR = b_dr; bus.B_Data = $urandom;
            #1;
            exp_a = (c % 2 == 0);
            n_vec++;
            if (bus.A_Ready !== exp_a || bus.B_Ready !== !exp_a) begin
                n_err++; $display("FAIL contention_grant%0d: A_Ready=%0b B_Ready=%0b want %0b/%0b", c, bus.A_Ready, bus.B_Ready, exp_a, !exp_a);
            end
            if (c > 0) begin
                n_vec++;
                if (bus.RegW !== 1'b1 || bus.DR !== prev_dr || bus.Reg_In !== prev_data) begin
                    n_err++; $display("FAIL contention_write%0d: RegW=%0b DR=%0d data=%h want 1/%0d/%h", c, bus.RegW, bus.DR, bus.Reg_In, prev_dr, prev_data);
                end
            end
            prev_dr   = exp_a ? a_dr : b_dr;
            prev_data = exp_a ? bus.A_Data : bus.B_Data;
            tick();
            if (exp_a) a_dr = a_dr + 5'd1;
            else       b_dr = b_dr + 5'd1;
        end
        bus.A_Valid = 1'b0; bus.B_Valid = 1'b0;
        #1;
        n_vec++; if (bus.RegW !== 1'b1 || bus.DR !== prev_dr) begin n_err++; $display("FAIL contention_last_write: RegW=%0b DR=%0d want 1/%0d", bus.RegW, bus.DR, prev_dr); end
        tick();
        #1;
        n_vec++; if (bus.Busy_Count !== 6'd4) begin n_err++; $display("FAIL contention_count: got %0d want 4", bus.Busy_Count); end
    endtask

    // Continues from test_contention: x3,x4,x7,x8 still busy, priority back at A
    task automatic test_single_b();
        int bd[3] = '{3, 4, 7};
        bus.B_Valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.B_DR = AW'(bd[k]); bus.B_Data = $urandom;
            #1;
            n_vec++;
            if (bus.B_Ready !== 1'b1 || bus.A_Ready !== 1'b0) begin
                n_err++; $display("FAIL single_b%0d: B_Ready=%0b A_Ready=%0b want 1/0", k, bus.B_Ready, bus.A_Ready);
            end
            tick();
        end
        bus.A_Valid = 1'b1; bus.A_DR = 5'd8; bus.A_Data = $urandom;
        bus.B_DR = 5'd0; bus.B_Data = $urandom;
        #1;
        n_vec++; if (bus.A_Ready !== 1'b1 || bus.B_Ready !== 1'b0) begin n_err++; $display("FAIL single_b_prio: A_Ready=%0b B_Ready=%0b want 1/0", bus.A_Ready, bus.B_Ready); end
        tick();
        bus.A_Valid = 1'b0;
        #1;
        n_vec++; if (bus.B_Ready !== 1'b1) begin n_err++; $display("FAIL single_b_after: B_Ready=%0b want 1", bus.B_Ready); end
        tick();
        idle_inputs();
        tick();
        tick();
        #1;
        n_vec++; if (bus.Busy_Count !== 6'd0 || bus.Err_Unexp !== 1'b0) begin n_err++; $display("FAIL single_b_drain: count=%0d err=%0b want 0/0", bus.Busy_Count, bus.Err_Unexp); end
    endtask

    task automatic test_x0();
        do_reset();
        set_issue(1, 0, 0, 0, 1);
        #1;
        n_vec++; if (bus.Issue_Stall !== 1'b0) begin n_err++; $display("FAIL x0_issue: stall=%0b want 0", bus.Issue_Stall); end
        tick();
        #1;
        n_vec++; if (bus.Busy_Count !== 6'd0 || bus.Issue_Stall !== 1'b0) begin n_err++; $display("FAIL x0_not_busy: count=%0d stall=%0b want 0/0", bus.Busy_Count, bus.Issue_Stall); end
        idle_inputs();
        bus.A_Valid = 1'b1; bus.A_DR = 5'd0; bus.A_Data = 32'hFFFF_FFFF;
        #1;
        n_vec++; if (bus.A_Ready !== 1'b1) begin n_err++; $display("FAIL x0_grant: A_Ready=%0b want 1", bus.A_Ready); end
        tick();
        bus.A_Valid = 1'b0;
        #1;
        n_vec++; if (bus.RegW !== 1'b0) begin n_err++; $display("FAIL x0_regw: got %0b want 0", bus.RegW); end
        tick();
        #1;
        n_vec++; if (bus.Err_Unexp !== 1'b0) begin n_err++; $display("FAIL x0_err: got %0b want 0", bus.Err_Unexp); end
    endtask

    task automatic test_unexpected();
        do_reset();
        bus.A_Valid = 1'b1; bus.A_DR = 5'd7; bus.A_Data = 32'h0000_CAFE;
        #1;
        tick();
        bus.A_Valid = 1'b0;
        #1;
        n_vec++; if (bus.RegW !== 1'b1 || bus.DR !== 5'd7) begin n_err++; $display("FAIL unexp_write: RegW=%0b DR=%0d want 1/7", bus.RegW, bus.DR); end
        n_vec++; if (bus.Err_Unexp !== 1'b0) begin n_err++; $display("FAIL unexp_early: err=%0b want 0", bus.Err_Unexp); end
        tick();
        #1;
        n_vec++; if (bus.Err_Unexp !== 1'b1) begin n_err++; $display("FAIL unexp_set: err=%0b want 1", bus.Err_Unexp); end
        repeat (3) tick();
        #1;
        n_vec++; if (bus.Err_Unexp !== 1'b1) begin n_err++; $display("FAIL unexp_sticky: err=%0b want 1", bus.Err_Unexp); end
        RST = 1'b1;
        model_reset();
        #1;
        n_vec++; if (bus.Err_Unexp !== 1'b0) begin n_err++; $display("FAIL unexp_reset: err=%0b want 0", bus.Err_Unexp); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        set_issue(1, 0, 0, 5, 1);
        tick();
        idle_inputs();
        bus.A_Valid = 1'b1; bus.A_DR = 5'd5; bus.A_Data = 32'h0000_DEAD;
        #1;
        n_vec++; if (bus.A_Ready !== 1'b1) begin n_err++; $display("FAIL midrst_grant: A_Ready=%0b want 1", bus.A_Ready); end
        tick();
        bus.A_Valid = 1'b0;
        #1;
        RST = 1'b1;
        model_reset();
        #1;
        n_vec++; if (bus.RegW !== 1'b0) begin n_err++; $display("FAIL midrst_regw: got %0b want 0", bus.RegW); end
        n_vec++; if (bus.Busy_Count !== 6'd0 || bus.Err_Unexp !== 1'b0) begin n_err++; $display("FAIL midrst_state: count=%0d err=%0b want 0/0", bus.Busy_Count, bus.Err_Unexp); end
        n_vec++; if (bus.Reg_In !== 32'd0) begin n_err++; $display("FAIL midrst_data: got %h want 0", bus.Reg_In); end
        @(negedge CLK);
        RST = 1'b0;
        tick();
        #1;
        n_vec++; if (bus.RegW !== 1'b0 || bus.Err_Unexp !== 1'b0) begin n_err++; $display("FAIL midrst_after: RegW=%0b err=%0b want 0/0", bus.RegW, bus.Err_Unexp); end
    endtask

    task automatic test_random();
        bit a_pend = 1'b0;
        bit b_pend = 1'b0;
        bit ag, bg;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            bus.Issue_Valid = ($urandom_range(0, 3) != 0);
            bus.Issue_SR1   = 5'($urandom_range(0, 7));
            bus.Issue_SR2   = 5'($urandom_range(0, 7));
            bus.Issue_DR    = 5'($urandom_range(0, 7));
            bus.Issue_WB    = ($urandom_range(0, 1) != 0);
            if (!a_pend && $urandom_range(0, 2) == 0) begin
                a_pend = 1'b1; bus.A_DR = pick_dr(); bus.A_Data = $urandom;
            end
            if (!b_pend && $urandom_range(0, 3) == 0) begin
                b_pend = 1'b1; bus.B_DR = pick_dr(); bus.B_Data = $urandom;
            end
            bus.A_Valid = a_pend;
            bus.B_Valid = b_pend;
            #1;
            ag = m_agnt();
            bg = m_bgnt();
            n_vec++;
            if (bus.Issue_Stall !== m_stall() || bus.A_Ready !== ag || bus.B_Ready !== bg) begin
                n_err++; $display("FAIL rand_comb@%0d: stall/ar/br=%0b%0b%0b want %0b%0b%0b", cyc, bus.Issue_Stall, bus.A_Ready, bus.B_Ready, m_stall(), ag, bg);
            end
            n_vec++;
            if (bus.RegW !== m_regw || bus.DR !== m_dr || bus.Reg_In !== m_data) begin
                n_err++; $display("FAIL rand_write@%0d: RegW=%0b DR=%0d data=%h want %0b/%0d/%h", cyc, bus.RegW, bus.DR, bus.Reg_In, m_regw, m_dr, m_data);
            end
            n_vec++;
            if (bus.Busy_Count !== 6'(m_count()) || bus.Err_Unexp !== m_err) begin
                n_err++; $display("FAIL rand_status@%0d: count=%0d err=%0b want %0d/%0b", cyc, bus.Busy_Count, bus.Err_Unexp, m_count(), m_err);
            end
            tick();
            if (ag) a_pend = 1'b0;
            if (bg) b_pend = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_contention();
        test_single_b();
        test_x0();
        test_unexpected();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Scheduler for the 32x32 register file's single write port. It arbitrates between two writeback sources: port A (ALU, single-cycle) and port B (load/store unit, variable latency). It also keeps a per-register scoreboard that stalls the issue stage on read-after-write (RAW) and write-after-write (WAW) hazards. It sits between issue/execute and the register file, and drives the file's RegW/DR/Reg_In write inputs.

Parameters:
XLEN, 32, data width of Reg_In and the source data buses
NREG, 32, number of architectural registers; x0 is hardwired zero
AW, 5, register index width (log2 NREG)

Ports:
CLK  input  1  clock, all state updates on posedge
RST  input  1  reset, asynchronous, active-high
Issue_Valid  input  1  issue stage presents an instruction
Issue_SR1  input  AW  source register 1 index
Issue_SR2  input  AW  source register 2 index
Issue_DR  input  AW  destination register index
Issue_WB  input  1  instruction will write Issue_DR
Issue_Stall  output  1  hold issue; instruction not accepted this cycle
A_Valid  input  1  ALU writeback request
A_DR  input  AW  ALU destination index
A_Data  input  XLEN  ALU result
A_Ready  output  1  ALU request granted this cycle
B_Valid  input  1  LSU writeback request
B_DR  input  AW  LSU destination index
B_Data  input  XLEN  LSU load data
B_Ready  output  1  LSU request granted this cycle
RegW  output  1  register file write enable (registered)
DR  output  AW  register file write index (registered)
Reg_In  output  XLEN  register file write data (registered)
Busy_Count  output  6  number of registers with a pending write
Err_Unexp  output  1  sticky flag: writeback hit a non-busy register

Behaviour:
- Reset (RST=1, asynchronous): busy[31:0]=0, Prio=A, RegW=0, DR=0, Reg_In=0, Busy_Count=0, Err_Unexp=0. Any in-flight write is discarded.
- Scoreboard: busy[0] is constant 0.
- Issue_Stall (combinational) = Issue_Valid && (busy[SR1] || busy[SR2] || (Issue_WB && busy[DR])).
- Issue is accepted when Issue_Valid && !Issue_Stall. On acceptance with Issue_WB=1 and DR!=0, busy[DR] is set at the next edge.
- Writeback handshake: a transfer happens when Valid && Ready. Sources hold Valid, DR and Data stable until Ready. Ready is combinational and never asserts without Valid.
- Arbitration:
  - Only one source valid: that source is granted.
  - Both valid: the source named by Prio is granted, and Prio flips to the other source at the edge.
  - Prio changes only on contention cycles. At most one grant per cycle.
- Output stage: at the edge a transfer occurs, RegW=1 (0 if the granted DR==0), DR and Reg_In are loaded from the granted source. With no transfer, RegW=0 and DR/Reg_In hold their values.
- Latency: grant in cycle N, RegW high in cycle N+1, register file written at the end of N+1.
- Busy clear: at the edge ending a cycle with RegW=1, busy[DR] is cleared. A dependent instruction is therefore unstalled in cycle N+2 and reads the new value.
- Error flag: if RegW=1 and busy[DR]=0 at that edge, Err_Unexp sets. It stays set until RST. The write still occurs.
- Set and clear of the same register at one edge cannot occur: the DR-busy stall blocks issue. If both occur for different registers, both take effect.
- Busy_Count = popcount(busy). It updates in the same edge as busy, so a simultaneous set and clear leaves it unchanged.
- Back-to-back grants to the same or different registers are legal, giving one write per cycle.

Test Plan:
- Reset mid-write: A grant to x5 with data 0xDEAD, RST asserted in the next cycle → RegW=0, Busy_Count=0, x5 not written, Err_Unexp=0.
- RAW stall: issue ADD DR=x3, then issue SR1=x3 → Issue_Stall=1 until the ALU writes x3 (RegW=1, DR=3), deasserts the following cycle; Busy_Count goes 1→0.
- Contention: A_Valid and B_Valid held for 4 cycles after reset with different DRs (all busy) → grants alternate A,B,A,B; Ready one-hot; RegW=1 every cycle from cycle 2.
- Single requester: B_Valid alone for 3 cycles → B_Ready=1 each cycle, Prio unchanged (next contention grants A).
- x0 handling: issue DR=x0 with Issue_WB=1 → no busy bit set, no stall. Writeback to x0 → RegW=0, Err_Unexp unchanged.
- Unexpected write: A writes x7 while busy[7]=0 → RegW=1, DR=7, Err_Unexp=1 persisting until RST.
